// File: rtl/mpram_write_arbiter.sv
// mpram_write_arbiter
//   Write-side front end for the LVT multi-port RAM. Each write port owns one
//   holding slot. Held slots that target the same address are serialized:
//   the oldest slot wins, ties go to the lowest port index. Winners are
//   registered onto the RAM write ports, so the RAM never sees two enabled
//   write ports with the same address in one cycle.
//
// Ports
//   clk, a_rst      : clock, asynchronous active-high reset
//   valid_i/ready_o : per-port request handshake
//   waddr_i/we_i/data_i : per-port request payload
//   en_w_o/we_o/waddr_o/data_o : registered RAM write ports (index i -> i)
//   idle_o          : no slot held and no RAM write enabled

// Per-port holding slot plus its registered RAM write port.
module mpram_write_arbiter_slot #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64,
    parameter int BYTES_NUM  = 1,
    parameter int AGE_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  a_rst,
    input  logic                  valid_i,
    input  logic                  blocked_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [BYTES_NUM-1:0]  we_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  held_o,
    output logic [AGE_WIDTH-1:0]  age_o,
    output logic [ADDR_WIDTH-1:0] slot_addr_o,
    output logic                  en_w_o,
    output logic [BYTES_NUM-1:0]  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = {AGE_WIDTH{1'b1}};

    logic                  held_q, held_d;
    logic [AGE_WIDTH-1:0]  age_q, age_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BYTES_NUM-1:0]  we_q, we_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  en_q, en_d;
    logic [BYTES_NUM-1:0]  rwe_q, rwe_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic issue;
    logic accept;

    assign issue   = held_q & ~blocked_i;
    // Issuing frees the slot this edge, so a new request can land in it
    // at the same edge without a bubble.
    assign ready_o = (~held_q | issue) & ~a_rst;
    assign accept  = valid_i & ready_o;

    always_comb begin
        held_d  = held_q;
        age_d   = age_q;
        addr_d  = addr_q;
        we_d    = we_q;
        data_d  = data_q;
        en_d    = 1'b0;
        rwe_d   = rwe_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;

        if (issue) begin
            en_d    = 1'b1;
            rwe_d   = we_q;
            raddr_d = addr_q;
            rdata_d = data_q;
        end

        if (accept) begin
            held_d = 1'b1;
            age_d  = '0;
            addr_d = addr_i;
            we_d   = we_i;
            data_d = data_i;
        end else if (issue) begin
            held_d = 1'b0;
            age_d  = '0;
        end else if (held_q && age_q != AGE_MAX) begin
            // held and not issued means blocked: grow older
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            held_q  <= 1'b0;
            age_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            rwe_q   <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            held_q  <= held_d;
            age_q   <= age_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            data_q  <= data_d;
            en_q    <= en_d;
            rwe_q   <= rwe_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

    assign held_o      = held_q;
    assign age_o       = age_q;
    assign slot_addr_o = addr_q;
    assign en_w_o      = en_q;
    assign we_o        = rwe_q;
    assign waddr_o     = raddr_q;
    assign data_o      = rdata_q;
endmodule

module mpram_write_arbiter #(
    parameter int DATA_DEPTH       = 128,
    parameter int DATA_WIDTH       = 64,
    parameter int WPORTS_NUM       = 6,
    parameter int BYTE_WRITE_WIDTH = 64,
    localparam int ADDR_WIDTH      = $clog2(DATA_DEPTH),
    localparam int BYTES_NUM       = DATA_WIDTH / BYTE_WRITE_WIDTH,
    localparam int AGE_WIDTH       = $clog2(WPORTS_NUM) + 1
) (
    input  logic                                  clk,
    input  logic                                  a_rst,
    input  logic [WPORTS_NUM-1:0]                 valid_i,
    output logic [WPORTS_NUM-1:0]                 ready_o,
    input  logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] waddr_i,
    input  logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  we_i,
    input  logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] data_i,
    output logic [WPORTS_NUM-1:0]                 en_w_o,
    output logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  we_o,
    output logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] waddr_o,
    output logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] data_o,
    output logic                                  idle_o
);
    logic [WPORTS_NUM-1:0]                 held;
    logic [WPORTS_NUM-1:0]                 blocked;
    logic [WPORTS_NUM-1:0][AGE_WIDTH-1:0]  slot_age;
    logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] slot_addr;

    // A held slot yields to any other held slot on the same address that is
    // older, or equally old with a lower port index. Byte enables are not
    // considered: same address always conflicts. Later arrivals start at age 0
    // while waiters only grow, so a waiter is never overtaken by a newcomer.
    always_comb begin
        blocked = '0;
        for (int j = 0; j < WPORTS_NUM; j++) begin
            for (int k = 0; k < WPORTS_NUM; k++) begin
                if (k != j && held[j] && held[k] && slot_addr[k] == slot_addr[j] &&
                    ((slot_age[k] > slot_age[j]) ||
                     ((slot_age[k] == slot_age[j]) && (k < j)))) begin
                    blocked[j] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < WPORTS_NUM; i++) begin : g_slot
        mpram_write_arbiter_slot #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .BYTES_NUM  (BYTES_NUM),
            .AGE_WIDTH  (AGE_WIDTH)
        ) u_slot (
            .clk         (clk),
            .a_rst       (a_rst),
            .valid_i     (valid_i[i]),
            .blocked_i   (blocked[i]),
            .addr_i      (waddr_i[i]),
            .we_i        (we_i[i]),
            .data_i      (data_i[i]),
            .ready_o     (ready_o[i]),
            .held_o      (held[i]),
            .age_o       (slot_age[i]),
            .slot_addr_o (slot_addr[i]),
            .en_w_o      (en_w_o[i]),
            .we_o        (we_o[i]),
            .waddr_o     (waddr_o[i]),
            .data_o      (data_o[i])
        );
    end

    assign idle_o = ~(|held) & ~(|en_w_o);
endmodule

// File: tb/tb_mpram_write_arbiter.sv
module tb_mpram_write_arbiter;
    localparam int NP = 6;
    localparam int AW = 7;
    localparam int DW = 64;
    localparam int BN = 1;

    logic                   clk;
    logic                   a_rst;
    logic [NP-1:0]          valid_i;
    logic [NP-1:0]          ready_o;
    logic [NP-1:0][AW-1:0]  waddr_i;
    logic [NP-1:0][BN-1:0]  we_i;
    logic [NP-1:0][DW-1:0]  data_i;
    logic [NP-1:0]          en_w_o;
    logic [NP-1:0][BN-1:0]  we_o;
    logic [NP-1:0][AW-1:0]  waddr_o;
    logic [NP-1:0][DW-1:0]  data_o;
    logic                   idle_o;

    mpram_write_arbiter #(
        .DATA_DEPTH(128), .DATA_WIDTH(DW), .WPORTS_NUM(NP), .BYTE_WRITE_WIDTH(64)
    ) dut (
        .clk(clk), .a_rst(a_rst), .valid_i(valid_i), .ready_o(ready_o),
        .waddr_i(waddr_i), .we_i(we_i), .data_i(data_i), .en_w_o(en_w_o),
        .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .idle_o(idle_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [BN-1:0] we;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq [NP][$];
    logic [DW-1:0] ram [128];
    int            total = 0;
    int            bad = 0;
    int            nwrites = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop/compare RAM writes, check the no-duplicate-address
    // invariant, then record requests that will be accepted at the next edge.
    always @(negedge clk) begin
        if (!a_rst) begin
            for (int p = 0; p < NP; p++) begin
                if (en_w_o[p]) begin
                    total++;
                    if (sbq[p].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write port %0d: got addr %0h data %0h, want no write", p, waddr_o[p], data_o[p]);
                    end else begin
                        exp_t e;
                        e = sbq[p].pop_front();
                        if (waddr_o[p] !== e.addr || data_o[p] !== e.data || we_o[p] !== e.we) begin
                            bad++;
                            $display("FAIL write_payload port %0d: got a=%0h d=%0h we=%0h, want a=%0h d=%0h we=%0h",
                                     p, waddr_o[p], data_o[p], we_o[p], e.addr, e.data, e.we);
                        end
                    end
                    ram[waddr_o[p]] = data_o[p];
                    nwrites++;
                end
            end
            total++;
            begin
                int dup;
                dup = 0;
                for (int p = 0; p < NP; p++)
                    for (int q = p + 1; q < NP; q++)
                        if (en_w_o[p] && en_w_o[q] && waddr_o[p] == waddr_o[q]) dup++;
                if (dup !== 0) begin
                    bad++;
                    $display("FAIL addr_conflict: got %0d duplicate enabled pairs, want 0 (en=%b)", dup, en_w_o);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (valid_i[p] && ready_o[p]) begin
                    exp_t e;
                    e.addr = waddr_i[p];
                    e.we   = we_i[p];
                    e.data = data_i[p];
                    sbq[p].push_back(e);
                end
            end
        end
    end

    task automatic drive(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BN-1:0] w);
        valid_i[p] = 1'b1;
        waddr_i[p] = a;
        data_i[p]  = d;
        we_i[p]    = w;
    endtask

    task automatic idle_all();
        valid_i = '0;
    endtask

    task automatic chk_en(input string name, input logic [NP-1:0] want);
        total++;
        if (en_w_o !== want) begin
            bad++;
            $display("FAIL %s: got en_w_o=%b, want %b", name, en_w_o, want);
        end
    endtask

    task automatic chk_rdy(input string name, input logic [NP-1:0] want);
        total++;
        if (ready_o !== want) begin
            bad++;
            $display("FAIL %s: got ready_o=%b, want %b", name, ready_o, want);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (ready_o !== '0 || en_w_o !== '0 || idle_o !== 1'b1 || waddr_o !== '0 || data_o !== '0 || we_o !== '0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b en=%b idle=%b, want 0/0/1 and zero outputs", ready_o, en_w_o, idle_o);
        end
        repeat (2) @(posedge clk);
        #1 a_rst = 1'b0;
        #1 chk_rdy("ready_after_reset", 6'h3F);
        total++;
        if (idle_o !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: got %b, want 1", idle_o);
        end
        // mid-traffic reset with slots 1,2,3 held and port 0 writing
        @(posedge clk); #1;
        drive(0, 7'h20, 64'h11, 1'b1);
        drive(1, 7'h20, 64'h12, 1'b1);
        drive(2, 7'h20, 64'h13, 1'b1);
        @(posedge clk); #1;
        idle_all();
        drive(3, 7'h30, 64'h14, 1'b1);
        @(posedge clk); #1;
        idle_all();
        chk_en("pre_reset_en", 6'b000001);
        total++;
        if (idle_o !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_idle: got %b, want 0", idle_o);
        end
        #1 a_rst = 1'b1;
        #1 chk_en("reset_en_immediate", 6'b0);
        chk_rdy("ready_in_reset", 6'b0);
        for (int p = 0; p < NP; p++) sbq[p].delete();
        @(posedge clk); #1 a_rst = 1'b0;
        #1 chk_rdy("ready_after_mid_reset", 6'h3F);
        total++;
        if (idle_o !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_mid_reset: got %b, want 1", idle_o);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk_en("no_stale_write", 6'b0);
        end
    endtask

    task automatic test_parallel();
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) drive(p, AW'(p), 64'hA0 + 64'(p), 1'b1);
        @(posedge clk); #1 idle_all();
        chk_en("parallel_not_early", 6'b0);
        @(posedge clk); #1;
        chk_en("parallel_en", 6'h3F);
        for (int p = 0; p < NP; p++) begin
            total++;
            if (waddr_o[p] !== AW'(p) || data_o[p] !== 64'hA0 + 64'(p)) begin
                bad++;
                $display("FAIL parallel_payload port %0d: got a=%0h d=%0h, want a=%0h d=%0h",
                         p, waddr_o[p], data_o[p], p, 64'hA0 + 64'(p));
            end
        end
        @(posedge clk); #1 chk_en("parallel_done", 6'b0);
    endtask

    task automatic test_stream();
        int n0;
        n0 = nwrites;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c >= 1) chk_rdy("stream_ready", 6'h3F);
            if (c >= 2) chk_en("stream_en", 6'h3F);
            for (int p = 0; p < NP; p++) drive(p, AW'(8 + 6 * c + p), 64'hB000 + 64'(16 * c + p), 1'b1);
        end
        @(posedge clk); #1 idle_all();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (nwrites - n0 !== 48) begin
            bad++;
            $display("FAIL stream_count: got %0d writes, want 48", nwrites - n0);
        end
    endtask

    task automatic test_conflict();
        @(posedge clk); #1;
        drive(1, 7'h10, 64'd1, 1'b1);
        drive(3, 7'h10, 64'd3, 1'b1);
        drive(4, 7'h10, 64'd4, 1'b1);
        @(posedge clk); #1 idle_all();
        chk_rdy("conflict_ready0", 6'b100111);
        @(posedge clk); #1;
        chk_en("conflict_en_p1", 6'b000010);
        chk_rdy("conflict_ready1", 6'b101111);
        @(posedge clk); #1;
        chk_en("conflict_en_p3", 6'b001000);
        chk_rdy("conflict_ready2", 6'h3F);
        @(posedge clk); #1;
        chk_en("conflict_en_p4", 6'b010000);
        @(posedge clk); #1;
        total++;
        if (ram[7'h10] !== 64'd4) begin
            bad++;
            $display("FAIL conflict_final: got %0h, want 4", ram[7'h10]);
        end
    endtask

    task automatic test_age();
        @(posedge clk); #1;
        drive(2, 7'h07, 64'h22, 1'b1);
        drive(5, 7'h07, 64'h55, 1'b1);
        @(posedge clk); #1 idle_all();
        drive(0, 7'h07, 64'hAA, 1'b1);
        @(posedge clk); #1 idle_all();
        chk_en("age_en_p2", 6'b000100);
        @(posedge clk); #1;
        chk_en("age_en_p5_first", 6'b100000);
        @(posedge clk); #1;
        chk_en("age_en_p0_last", 6'b000001);
        @(posedge clk); #1;
        total++;
        if (ram[7'h07] !== 64'hAA) begin
            bad++;
            $display("FAIL age_final: got %0h, want aa", ram[7'h07]);
        end
    endtask

    task automatic test_bytemask();
        @(posedge clk); #1;
        drive(0, 7'h03, 64'h0F, 1'b1);
        drive(2, 7'h03, 64'hF0, 1'b1);
        @(posedge clk); #1 idle_all();
        @(posedge clk); #1 chk_en("mask_en_p0", 6'b000001);
        @(posedge clk); #1 chk_en("mask_en_p2", 6'b000100);
        // all-zero masks still conflict
        drive(1, 7'h09, 64'h91, 1'b0);
        drive(4, 7'h09, 64'h94, 1'b0);
        @(posedge clk); #1 idle_all();
        @(posedge clk); #1 chk_en("zmask_en_p1", 6'b000010);
        @(posedge clk); #1 chk_en("zmask_en_p4", 6'b010000);
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        drive(1, 7'h40, 64'h111, 1'b1);
        drive(2, 7'h40, 64'h222, 1'b1);
        @(posedge clk); #1;
        valid_i[1] = 1'b0;
        total++;
        if (ready_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL bp_stalled: got ready_o[2]=%b, want 0", ready_o[2]);
        end
        drive(2, 7'h41, 64'h333, 1'b1);
        @(posedge clk); #1;
        chk_en("bp_en_p1", 6'b000010);
        total++;
        if (ready_o[2] !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_on_issue: got ready_o[2]=%b, want 1", ready_o[2]);
        end
        @(posedge clk); #1 idle_all();
        chk_en("bp_en_old", 6'b000100);
        total++;
        if (data_o[2] !== 64'h222 || waddr_o[2] !== 7'h40) begin
            bad++;
            $display("FAIL bp_old_data: got a=%0h d=%0h, want a=40 d=222", waddr_o[2], data_o[2]);
        end
        @(posedge clk); #1;
        chk_en("bp_en_new", 6'b000100);
        total++;
        if (data_o[2] !== 64'h333 || waddr_o[2] !== 7'h41) begin
            bad++;
            $display("FAIL bp_new_data: got a=%0h d=%0h, want a=41 d=333", waddr_o[2], data_o[2]);
        end
        @(posedge clk); #1;
        chk_en("bp_idle", 6'b0);
        total++;
        if (data_o[2] !== 64'h333 || waddr_o[2] !== 7'h41) begin
            bad++;
            $display("FAIL bp_hold: got a=%0h d=%0h, want a=41 d=333", waddr_o[2], data_o[2]);
        end
    endtask

    task automatic test_drain();
        int left;
        repeat (3) @(posedge clk);
        #1;
        left = 0;
        for (int p = 0; p < NP; p++) left += sbq[p].size();
        total++;
        if (left !== 0 || idle_o !== 1'b1) begin
            bad++;
            $display("FAIL drain: got %0d pending, idle=%b, want 0 pending, idle=1", left, idle_o);
        end
    endtask

    initial begin
        a_rst   = 1'b1;
        valid_i = '0;
        waddr_i = '0;
        we_i    = '0;
        data_i  = '0;
        test_reset();
        test_parallel();
        test_stream();
        test_conflict();
        test_age();
        test_bytemask();
        test_backpressure();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
